// File: rtl/lock_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lock_session_ctrl
//  Purpose  : Session controller for the password lock datapath. Sequences
//             set-password and unlock sessions from keypad events, counts
//             digits, drives the register-chain strobes, and enforces a
//             fail counter with a timed lockout.
//  Revision : 1.0 - initial release
// ============================================================================
module lock_session_ctrl #(
  parameter int DIGITS        = 4,
  parameter int MAX_FAIL      = 3,
  parameter int OPEN_CYCLES   = 500,
  parameter int LOCK_CYCLES   = 1000,
  parameter int ENTRY_TIMEOUT = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_valid,
  input  logic       i_enter,
  input  logic       i_mode,
  input  logic       i_aeqb,
  output logic       o_ld_save,
  output logic       o_ld_input,
  output logic       o_clr_input,
  output logic [2:0] o_digit_cnt,
  output logic [2:0] o_fail_cnt,
  output logic       o_pwd_valid,
  output logic       o_open,
  output logic       o_error,
  output logic       o_lockout
);

  localparam logic [2:0]  c_digits   = 3'(DIGITS);
  localparam logic [2:0]  c_max_fail = 3'(MAX_FAIL);
  localparam logic [15:0] c_open_tc  = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] c_lock_tc  = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] c_entry_tc = 16'(ENTRY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SET_ENTRY    = 3'd1,
    ST_SET_ERR      = 3'd2,
    ST_UNLOCK_ENTRY = 3'd3,
    ST_CHECK        = 3'd4,
    ST_OPEN         = 3'd5,
    ST_FAIL         = 3'd6,
    ST_LOCKED       = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_timer;
  logic [2:0]  r_digit_cnt;
  logic [2:0]  r_fail_cnt;
  logic [2:0]  w_fail_inc;
  logic        r_pwd_valid;
  logic        r_clr_input;
  logic        r_open;
  logic        r_error;
  logic        r_lockout;
  logic        w_key;
  logic        w_full;
  logic        w_entry;
  logic        w_entry_to;
  logic        w_ld_save;
  logic        w_ld_input;

  // Next-state decision and Mealy load strobes; ENTER always masks a coincident key
  always_comb begin
    w_key      = i_key_valid & ~i_enter;
    w_full     = (r_digit_cnt == c_digits);
    w_entry    = (r_state == ST_SET_ENTRY) || (r_state == ST_UNLOCK_ENTRY);
    w_entry_to = w_entry && !i_key_valid && !i_enter && (r_timer == c_entry_tc);
    w_fail_inc = r_fail_cnt + 3'd1;
    w_next     = r_state;
    w_ld_save  = 1'b0;
    w_ld_input = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_key) begin
          if (!i_mode) begin
            w_next    = ST_SET_ENTRY;
            w_ld_save = 1'b1;
          end else if (r_pwd_valid) begin
            w_next     = ST_UNLOCK_ENTRY;
            w_ld_input = 1'b1;
          end
        end
      end
      ST_SET_ENTRY: begin
        if (i_enter)         w_next = w_full ? ST_IDLE : ST_SET_ERR;
        else if (w_entry_to) w_next = ST_IDLE;
        w_ld_save = w_key && !w_full;
      end
      ST_SET_ERR: w_next = ST_IDLE;
      ST_UNLOCK_ENTRY: begin
        if (i_enter)         w_next = w_full ? ST_CHECK : ST_FAIL;
        else if (w_entry_to) w_next = ST_IDLE;
        w_ld_input = w_key && !w_full;
      end
      ST_CHECK: w_next = i_aeqb ? ST_OPEN : ST_FAIL;
      ST_OPEN: begin
        if (r_timer == c_open_tc) w_next = ST_IDLE;
      end
      ST_FAIL: w_next = (w_fail_inc >= c_max_fail) ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: begin
        if (r_timer == c_lock_tc) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, timer, counters and registered state-decode outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_pwd_valid <= 1'b0;
      r_clr_input <= 1'b0;
      r_open      <= 1'b0;
      r_error     <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_state <= w_next;

      // Any key inside an entry session restarts the idle window
      if ((w_next != r_state) || (w_entry && i_key_valid)) r_timer <= '0;
      else                                                r_timer <= r_timer + 16'd1;

      if ((w_next == ST_IDLE) && (r_state != ST_IDLE)) r_digit_cnt <= '0;
      else if (w_ld_save || w_ld_input)                 r_digit_cnt <= r_digit_cnt + 3'd1;

      if ((r_state == ST_CHECK) && i_aeqb)                      r_fail_cnt <= '0;
      else if (r_state == ST_FAIL)                              r_fail_cnt <= w_fail_inc;
      else if ((r_state == ST_LOCKED) && (w_next == ST_IDLE))   r_fail_cnt <= '0;

      // Leaving a set session: only a full-length ENTER commits the password
      if ((r_state == ST_SET_ENTRY) && (w_next != ST_SET_ENTRY))
        r_pwd_valid <= (w_next == ST_IDLE) && i_enter;

      r_clr_input <= (w_next == ST_IDLE) &&
                     ((r_state == ST_UNLOCK_ENTRY) || (r_state == ST_FAIL) ||
                      (r_state == ST_OPEN) || (r_state == ST_LOCKED));
      r_open      <= (w_next == ST_OPEN);
      r_error     <= (w_next == ST_SET_ERR) || (w_next == ST_FAIL);
      r_lockout   <= (w_next == ST_LOCKED);
    end
  end

  assign o_ld_save   = w_ld_save & i_rst_n;
  assign o_ld_input  = w_ld_input & i_rst_n;
  assign o_clr_input = r_clr_input;
  assign o_digit_cnt = r_digit_cnt;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_pwd_valid = r_pwd_valid;
  assign o_open      = r_open;
  assign o_error     = r_error;
  assign o_lockout   = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_lock_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_session_ctrl
//  Purpose  : Self-checking bench for lock_session_ctrl: directed sessions
//             followed by randomized keypad traffic, checked every cycle
//             against a countdown-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lock_session_ctrl;

  localparam int DIGITS        = 4;
  localparam int MAX_FAIL      = 3;
  localparam int OPEN_CYCLES   = 5;
  localparam int LOCK_CYCLES   = 8;
  localparam int ENTRY_TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0, enter = 1'b0, mode = 1'b0, aeqb = 1'b0;
  logic       o_ld_save, o_ld_input, o_clr_input, o_pwd_valid, o_open, o_error, o_lockout;
  logic [2:0] o_digit_cnt, o_fail_cnt;

  lock_session_ctrl #(
    .DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_valid(key), .i_enter(enter),
    .i_mode(mode), .i_aeqb(aeqb), .o_ld_save(o_ld_save), .o_ld_input(o_ld_input),
    .o_clr_input(o_clr_input), .o_digit_cnt(o_digit_cnt), .o_fail_cnt(o_fail_cnt),
    .o_pwd_valid(o_pwd_valid), .o_open(o_open), .o_error(o_error), .o_lockout(o_lockout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_save, obs_input, obs_open, obs_err, obs_lock, obs_clr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Session kind (0 none, 1 setting, 2 unlocking) plus countdowns for timed phases.
  int m_kind, m_idle_left, m_open_left, m_lock_left, m_cnt, m_fails;
  bit m_err, m_err_fail, m_chk, m_clr, m_pv;

  always @(negedge clk) begin : cmp
    bit e_save, e_input, quiet_idle, nclr;
    if (!rst_n) begin
      m_kind = 0; m_idle_left = 0; m_open_left = 0; m_lock_left = 0;
      m_cnt = 0; m_fails = 0; m_err = 0; m_err_fail = 0; m_chk = 0; m_clr = 0; m_pv = 0;
      check("rst_ld_save", o_ld_save, 0);
      check("rst_ld_input", o_ld_input, 0);
      check("rst_clr_input", o_clr_input, 0);
      check("rst_digit_cnt", o_digit_cnt, 0);
      check("rst_fail_cnt", o_fail_cnt, 0);
      check("rst_pwd_valid", o_pwd_valid, 0);
      check("rst_open", o_open, 0);
      check("rst_error", o_error, 0);
      check("rst_lockout", o_lockout, 0);
    end else begin
      quiet_idle = (m_kind == 0) && !m_err && !m_chk && (m_open_left == 0) && (m_lock_left == 0);
      e_save  = key && !enter && ((quiet_idle && !mode) || (m_kind == 1 && m_cnt < DIGITS));
      e_input = key && !enter && ((quiet_idle && mode && m_pv) || (m_kind == 2 && m_cnt < DIGITS));
      check("ld_save", o_ld_save, e_save);
      check("ld_input", o_ld_input, e_input);
      check("clr_input", o_clr_input, m_clr);
      check("digit_cnt", o_digit_cnt, m_cnt);
      check("fail_cnt", o_fail_cnt, m_fails);
      check("pwd_valid", o_pwd_valid, m_pv);
      check("open", o_open, m_open_left > 0);
      check("error", o_error, m_err);
      check("lockout", o_lockout, m_lock_left > 0);
      obs_save  += o_ld_save;
      obs_input += o_ld_input;
      obs_open  += o_open;
      obs_err   += o_error;
      obs_lock  += o_lockout;
      obs_clr   += o_clr_input;

      // advance the model using the inputs that the next rising edge samples
      nclr = 0;
      if (m_err) begin
        m_err = 0;
        if (m_err_fail) begin
          m_fails++;
          if (m_fails >= MAX_FAIL) m_lock_left = LOCK_CYCLES;
          else begin m_cnt = 0; nclr = 1; end
        end else m_cnt = 0;
      end else if (m_chk) begin
        m_chk = 0;
        if (aeqb) begin m_fails = 0; m_open_left = OPEN_CYCLES; end
        else begin m_err = 1; m_err_fail = 1; end
      end else if (m_open_left > 0) begin
        m_open_left--;
        if (m_open_left == 0) begin m_cnt = 0; nclr = 1; end
      end else if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_fails = 0; m_cnt = 0; nclr = 1; end
      end else if (m_kind != 0) begin
        if (enter) begin
          if (m_kind == 1) begin
            m_pv = (m_cnt == DIGITS);
            if (m_pv) m_cnt = 0;
            else begin m_err = 1; m_err_fail = 0; end
          end else begin
            if (m_cnt == DIGITS) m_chk = 1;
            else begin m_err = 1; m_err_fail = 1; end
          end
          m_kind = 0;
        end else if (key) begin
          m_idle_left = ENTRY_TIMEOUT;
          if (m_cnt < DIGITS) m_cnt++;
        end else begin
          m_idle_left--;
          if (m_idle_left == 0) begin
            if (m_kind == 1) m_pv = 0; else nclr = 1;
            m_kind = 0; m_cnt = 0;
          end
        end
      end else if (key && !enter) begin
        if (!mode) begin m_kind = 1; m_cnt = 1; m_idle_left = ENTRY_TIMEOUT; end
        else if (m_pv) begin m_kind = 2; m_cnt = 1; m_idle_left = ENTRY_TIMEOUT; end
      end
      m_clr = nclr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit k, input bit e, input bit m, input bit a);
    @(posedge clk); #1;
    key = k; enter = e; mode = m; aeqb = a;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, mode, aeqb);
  endtask

  task automatic keys(input int n, input bit m, input bit a);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, m, a);
      drive(1'b0, 1'b0, m, a);
    end
  endtask

  task automatic clr_obs();
    obs_save = 0; obs_input = 0; obs_open = 0; obs_err = 0; obs_lock = 0; obs_clr = 0;
  endtask

  task automatic set_full();
    keys(DIGITS, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    quiet(2);
  endtask

  initial begin
    clr_obs();
    rst_n = 1'b0;
    quiet(3);
    check("lit_reset_digit_cnt", o_digit_cnt, 0);
    check("lit_reset_pwd_valid", o_pwd_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    quiet(2);

    // set password 1-2-3-4
    clr_obs();
    set_full();
    check("lit_set_ld_save_pulses", obs_save, 4);
    check("lit_set_pwd_valid", o_pwd_valid, 1);
    check("lit_set_no_error", obs_err, 0);

    // correct unlock
    clr_obs();
    keys(DIGITS, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);            // ENTER sampled at edge k
    drive(1'b0, 1'b0, 1'b1, 1'b1);            // cycle k+1 : compare settle
    @(negedge clk);
    check("lit_open_low_in_check", o_open, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);            // cycle k+2
    @(negedge clk);
    check("lit_open_high_k2", o_open, 1);
    quiet(OPEN_CYCLES + 2);
    check("lit_open_duration", obs_open, OPEN_CYCLES);
    check("lit_open_clr_pulses", obs_clr, 1);
    check("lit_open_fail_cnt", o_fail_cnt, 0);
    check("lit_open_ld_input_pulses", obs_input, 4);

    // three wrong unlocks -> lockout
    for (int a = 0; a < MAX_FAIL; a++) begin
      keys(DIGITS, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("lit_wrong_error_k2", o_error, 1);
      if (a < MAX_FAIL - 1) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_wrong_fail_cnt", o_fail_cnt, a + 1);
      end
    end
    for (int i = 0; i < LOCK_CYCLES; i++) begin
      drive(i[0], 1'b0, 1'b1, 1'b0);
      if (i == 0) begin
        clr_obs();
        check("lit_lock_fail_cnt", o_fail_cnt, 3);
      end
    end
    quiet(3);
    check("lit_lock_no_ld_input", obs_input, 0);
    check("lit_lock_duration", obs_lock, LOCK_CYCLES);
    check("lit_lock_fail_cleared", o_fail_cnt, 0);

    // five digits saturate, then KEY_VALID with ENTER
    clr_obs();
    keys(5, 1'b1, 1'b1);
    check("lit_sat_digit_cnt", o_digit_cnt, 4);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("lit_collide_open", o_open, 1);
    quiet(OPEN_CYCLES + 2);
    check("lit_sat_ld_input_pulses", obs_input, 4);

    // short set -> SET_ERR, then unlock refused
    clr_obs();
    keys(2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lit_set_err_error", o_error, 1);
    quiet(1);
    check("lit_set_err_pwd_valid", o_pwd_valid, 0);
    check("lit_set_err_fail_cnt", o_fail_cnt, 0);
    check("lit_set_err_pulses", obs_err, 1);
    clr_obs();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    quiet(2);
    check("lit_nopwd_ld_input", obs_input, 0);
    check("lit_nopwd_digit_cnt", o_digit_cnt, 0);

    // entry timeouts
    clr_obs();
    keys(2, 1'b0, 1'b0);
    quiet(ENTRY_TIMEOUT - 3);
    check("lit_to_not_yet", o_digit_cnt, 2);
    quiet(5);
    check("lit_to_digit_cnt", o_digit_cnt, 0);
    check("lit_to_no_error", obs_err, 0);
    set_full();
    clr_obs();
    keys(2, 1'b1, 1'b0);
    quiet(ENTRY_TIMEOUT + 3);
    check("lit_to_unlock_clr", obs_clr, 1);
    check("lit_to_unlock_pwd_kept", o_pwd_valid, 1);

    // reset during OPEN
    keys(DIGITS, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    quiet(4);
    check("lit_pre_reset_open", o_open, 1);
    rst_n = 1'b0;
    #1;
    check("lit_reset_open_now", o_open, 0);
    check("lit_reset_pwd_cleared", o_pwd_valid, 0);
    quiet(2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 5) < 3, ($urandom % 2) == 1);
      rst_n = (($urandom % 400) != 0);
    end
    rst_n = 1'b1;
    quiet(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_session_ctrl.md
# lock_session_ctrl

Session controller for the password lock datapath. It sequences a set-password or unlock session from keypad events and counts digits. It drives the load and clear strobes of the datapath's stored-password and input-password register chains, and samples the datapath's equality flag to decide open or error. It also enforces a fail counter with a timed lockout, and sits between the keypad decoder and the lock datapath, replacing the free-running control FSM.

## Interface
- DIGITS, 4: password length in digits; 1..7
- MAX_FAIL, 3: consecutive unlock failures that trigger lockout; 1..7
- OPEN_CYCLES, 500: cycles OPEN stays high; 1..65535
- LOCK_CYCLES, 1000: lockout duration in cycles; 1..65535
- ENTRY_TIMEOUT, 2000: max idle cycles between events inside an entry session; 1..65535

- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- KEY_VALID  in  1  one-cycle pulse per digit press (CODE valid same cycle, captured by datapath)
- ENTER  in  1  one-cycle pulse, confirm key
- MODE  in  1  0 = set password, 1 = unlock; sampled only on session start
- AEQB  in  1  datapath stored == input password
- LD_SAVE  out  1  load strobe, stored-password chain
- LD_INPUT  out  1  load strobe, input-password chain
- CLR_INPUT  out  1  one-cycle clear, input-password chain
- DIGIT_CNT  out  3  digits accepted in current session
- FAIL_CNT  out  3  consecutive unlock failures
- PWD_VALID  out  1  a full-length password has been committed
- OPEN  out  1  lock open
- ERROR  out  1  one-cycle error indication
- LOCKOUT  out  1  lockout active, all keys ignored

## Operation
- States: IDLE, SET_ENTRY, SET_ERR, UNLOCK_ENTRY, CHECK, OPEN, FAIL, LOCKED. There is one 16-bit timer, reloaded on every state entry and on every accepted key.
- IDLE, KEY_VALID:
  - MODE=0: go to SET_ENTRY; digit accepted.
  - MODE=1 and PWD_VALID=1: go to UNLOCK_ENTRY; digit accepted.
  - MODE=1 and PWD_VALID=0: key ignored.
- IDLE, ENTER: ignored.
- Digit acceptance:
  - LD_SAVE (set) or LD_INPUT (unlock) is asserted combinationally in the same cycle as the accepted KEY_VALID, and DIGIT_CNT increments at that edge.
  - Once DIGIT_CNT==DIGITS, further KEY_VALID is ignored: no strobe, no increment.
- SET_ENTRY, ENTER:
  - DIGIT_CNT==DIGITS: set PWD_VALID=1, go to IDLE.
  - Otherwise: clear PWD_VALID, go to SET_ERR.
- SET_ERR: ERROR=1 for one cycle, then IDLE. FAIL_CNT is unchanged.
- UNLOCK_ENTRY, ENTER:
  - DIGIT_CNT==DIGITS: go to CHECK.
  - Otherwise: go to FAIL.
- CHECK: one cycle, allowing datapath compare settling. AEQB=1 leads to OPEN and FAIL_CNT=0; AEQB=0 leads to FAIL.
- FAIL: ERROR=1 for one cycle and FAIL_CNT increments. If the new value is ≥ MAX_FAIL, go to LOCKED; otherwise go to IDLE.
- OPEN: OPEN=1 while the timer counts OPEN_CYCLES, then go to IDLE. KEY_VALID and ENTER are ignored.
- LOCKED: LOCKOUT=1 for LOCK_CYCLES, then FAIL_CNT=0 and go to IDLE. Keys are ignored.
- Entry timeout: in SET_ENTRY or UNLOCK_ENTRY, if ENTRY_TIMEOUT cycles pass without KEY_VALID or ENTER, go to IDLE silently. There is no ERROR, FAIL_CNT is unchanged, and PWD_VALID is cleared only if the session was SET_ENTRY.
- CLR_INPUT pulses for one cycle on every transition into IDLE from UNLOCK_ENTRY, FAIL, OPEN or LOCKED.
- DIGIT_CNT returns to 0 on every transition into IDLE.
- Simultaneous KEY_VALID and ENTER: ENTER wins and the key is ignored (no strobe).
- MODE changes after session start are ignored.

## Timing
- Reset values: state IDLE, DIGIT_CNT=0, FAIL_CNT=0, PWD_VALID=0, OPEN=0, ERROR=0, LOCKOUT=0, CLR_INPUT=0, LD_SAVE=0, LD_INPUT=0, timer=0.
- Reset asserted mid-session aborts immediately and clears the committed password.
- OPEN, ERROR and LOCKOUT are state decodes. LD_SAVE and LD_INPUT are Mealy outputs, gated by state and DIGIT_CNT.
- Correct unlock: ENTER sampled at edge k, CHECK during cycle k+1, OPEN high from cycle k+2 for exactly OPEN_CYCLES cycles. CLR_INPUT is high in the first IDLE cycle.
- Wrong unlock: ERROR is high during cycle k+2 only.
- Short unlock (fewer than DIGITS digits): ERROR is high during cycle k+1.
- LOCKOUT is high for exactly LOCK_CYCLES cycles, starting the cycle after the FAIL cycle.
- The timer is 16 bits. Terminal count is value ==PARAM−1, so durations are exact.

## Test plan
- Set 1-2-3-4 (MODE=0, 4 KEY_VALID, ENTER) -> 4 LD_SAVE pulses, PWD_VALID=1, ERROR never high.
- Unlock with the correct digits (AEQB=1 in CHECK) -> OPEN high 2 cycles after ENTER for OPEN_CYCLES cycles, then CLR_INPUT pulse, FAIL_CNT=0.
- Three wrong unlocks (AEQB=0), MAX_FAIL=3 -> ERROR pulses, FAIL_CNT 1,2,3, then LOCKOUT for LOCK_CYCLES. Keys during LOCKOUT give no LD_INPUT. Afterwards FAIL_CNT=0.
- 5 digits then ENTER in unlock -> only 4 LD_INPUT pulses, DIGIT_CNT saturates at 4. KEY_VALID together with ENTER -> no strobe, ENTER acted on.
- Unlock attempt with PWD_VALID=0 -> no state change, no strobes. Set with 2 digits then ENTER -> SET_ERR ERROR pulse, PWD_VALID=0, FAIL_CNT unchanged.
- 2 digits, then no events for ENTRY_TIMEOUT cycles -> back to IDLE, DIGIT_CNT=0, no ERROR. RESET pulsed during OPEN -> OPEN=0 immediately, PWD_VALID=0.
